// File: rtl/edge_sched_pkg.sv
// Shared types, defaults and the round-robin search used by edge_event_scheduler.
package edge_sched_pkg;

    typedef enum logic {ST_IDLE, ST_OFFER} state_t;

    localparam int DEF_N           = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int MAX_N           = 16;
    localparam int IDX_W_MAX       = 4;

    // First set request found scanning upward from last+1, wrapping at n.
    function automatic logic [IDX_W_MAX-1:0] rr_pick(input logic [MAX_N-1:0]     req,
                                                     input logic [IDX_W_MAX-1:0] last,
                                                     input int                   n);
        logic [IDX_W_MAX-1:0] idx;
        logic [IDX_W_MAX-1:0] win;
        logic                 found;
        idx   = last;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                idx = (idx == IDX_W_MAX'(n - 1)) ? '0 : idx + 1'b1;
                if (req[idx] && !found) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One channel: synchronizer chain, delay flop and edge strobes.
// Falling-edge output exists only when EDGE_BOTH_EN is defined.
module edge_detect_chan #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
`ifdef EDGE_BOTH_EN
    output logic fall,
`endif
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
`ifdef EDGE_BOTH_EN
    assign fall = ~sync_q[SYNC_STAGES-1] & dly_q;
`endif

endmodule

// File: rtl/edge_event_scheduler.sv
// Latches edge events from N async lines and offers them round-robin on a valid/ready port.
// Define EDGE_BOTH_EN to also capture falling edges and report polarity on evt_rise.
module edge_event_scheduler
    import edge_sched_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         data_in,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [$clog2(N)-1:0] evt_id,
`ifdef EDGE_BOTH_EN
    output logic                 evt_rise,
`endif
    output logic [N-1:0]         pending,
    output logic [N-1:0]         overflow,
    input  logic [N-1:0]         ovf_clr
);

    localparam int ID_W = $clog2(N);

    logic [N-1:0]         rise_w;
    logic [N-1:0]         pend_rise_q, pend_rise_d;
    logic [N-1:0]         acc_rise;
    logic [N-1:0]         req;
    logic [N-1:0]         ovf_set;
    logic [N-1:0]         ovf_q, ovf_d;
    logic                 accept;
    logic [IDX_W_MAX-1:0] win;
    state_t               state_q, state_d;
    logic                 evt_valid_q, evt_valid_d;
    logic [ID_W-1:0]      evt_id_q, evt_id_d;
    logic [ID_W-1:0]      last_q, last_d;
`ifdef EDGE_BOTH_EN
    logic [N-1:0]         fall_w;
    logic [N-1:0]         pend_fall_q, pend_fall_d;
    logic [N-1:0]         acc_fall;
    logic                 evt_rise_q, evt_rise_d;
`endif

    for (genvar g = 0; g < N; g++) begin : g_chan
        edge_detect_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan (
            .clk  (clk),
            .rst  (rst),
            .din  (data_in[g]),
`ifdef EDGE_BOTH_EN
            .fall (fall_w[g]),
`endif
            .rise (rise_w[g])
        );
    end

    always_comb begin
`ifdef EDGE_BOTH_EN
        req = pend_rise_q | pend_fall_q;
`else
        req = pend_rise_q;
`endif
        accept   = evt_valid_q & evt_ready;
        win      = rr_pick(MAX_N'(req), IDX_W_MAX'(last_q), N);
        acc_rise = '0;
`ifdef EDGE_BOTH_EN
        acc_fall = '0;
`endif
        for (int i = 0; i < N; i++) begin
            if (accept && (evt_id_q == ID_W'(i))) begin
`ifdef EDGE_BOTH_EN
                if (evt_rise_q) acc_rise[i] = 1'b1;
                else            acc_fall[i] = 1'b1;
`else
                acc_rise[i] = 1'b1;
`endif
            end
        end

        // A fresh edge in the accept cycle re-arms the flag instead of counting as overflow.
        pend_rise_d = rise_w | (pend_rise_q & ~acc_rise);
        ovf_set     = rise_w & pend_rise_q & ~acc_rise;
`ifdef EDGE_BOTH_EN
        pend_fall_d = fall_w | (pend_fall_q & ~acc_fall);
        ovf_set     = ovf_set | (fall_w & pend_fall_q & ~acc_fall);
`endif
        ovf_d = (ovf_q & ~ovf_clr) | ovf_set;

        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        last_d      = last_q;
`ifdef EDGE_BOTH_EN
        evt_rise_d  = evt_rise_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    evt_id_d    = ID_W'(win);
                    evt_valid_d = 1'b1;
`ifdef EDGE_BOTH_EN
                    evt_rise_d  = pend_rise_q[evt_id_d];
`endif
                    state_d     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    last_d      = evt_id_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            last_q      <= ID_W'(N - 1);
            pend_rise_q <= '0;
            ovf_q       <= '0;
`ifdef EDGE_BOTH_EN
            pend_fall_q <= '0;
            evt_rise_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            last_q      <= last_d;
            pend_rise_q <= pend_rise_d;
            ovf_q       <= ovf_d;
`ifdef EDGE_BOTH_EN
            pend_fall_q <= pend_fall_d;
            evt_rise_q  <= evt_rise_d;
`endif
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign pending   = req;
    assign overflow  = ovf_q;
`ifdef EDGE_BOTH_EN
    assign evt_rise  = evt_rise_q;
`endif

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed and randomized bench for edge_event_scheduler (rising-edge build) against a sample-history model.
module tb_edge_event_scheduler;

    localparam int N    = 4;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] data_in;
    logic       evt_ready;
    logic [3:0] ovf_clr;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [3:0] pending;
    logic [3:0] overflow;

    int checks   = 0;
    int failures = 0;

    // Reference state: raw input samples (index 0 = newest) plus event bookkeeping.
    logic [3:0] samp [0:SYNC];
    logic [3:0] m_pend;
    logic [3:0] m_ovf;
    logic       m_valid;
    int         m_id;
    int         m_last;
    int         cyc;
    int         log_id [$];
    int         log_cyc [$];

    edge_event_scheduler #(.N(N), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .pending   (pending),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic [3:0] din, input logic rdy, input logic [3:0] clr);
        logic [3:0] rise, newpend, set;
        logic       acc;
        if (r) begin
            for (int j = 0; j <= SYNC; j++) samp[j] = '0;
            m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_id = 0; m_last = N - 1;
            return;
        end
        rise    = samp[SYNC-1] & ~samp[SYNC];
        acc     = m_valid && rdy;
        newpend = '0;
        set     = '0;
        for (int i = 0; i < N; i++) begin
            logic a;
            a = acc && (m_id == i);
            newpend[i] = rise[i] || (m_pend[i] && !a);
            set[i]     = rise[i] && m_pend[i] && !a;
        end
        if (m_valid) begin
            if (rdy) begin
                log_id.push_back(m_id);
                log_cyc.push_back(cyc);
                m_last  = m_id;
                m_valid = 1'b0;
            end
        end else if (m_pend != 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_pend[c] && !m_valid) begin
                    m_id    = c;
                    m_valid = 1'b1;
                end
            end
        end
        for (int j = SYNC; j >= 1; j--) samp[j] = samp[j-1];
        samp[0] = din;
        m_pend  = newpend;
        m_ovf   = (m_ovf & ~clr) | set;
    endtask

    task automatic step(input logic r, input logic [3:0] din, input logic rdy, input logic [3:0] clr);
        rst = r; data_in = din; evt_ready = rdy; ovf_clr = clr;
        @(posedge clk);
        model(r, din, rdy, clr);
        cyc++;
        #1;
        check("evt_valid", 32'(evt_valid), 32'(m_valid));
        check("evt_id",    32'(evt_id),    32'(m_id));
        check("pending",   32'(pending),   32'(m_pend));
        check("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    initial begin
        int first;
        int base;
        int n1;
        logic [3:0] d;
        cyc = 0;
        for (int j = 0; j <= SYNC; j++) samp[j] = '0;
        m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_id = 0; m_last = N - 1;

        // Reset state
        step(1, 4'b0000, 0, 4'b0000);
        step(1, 4'b0000, 0, 4'b0000);
        check("reset_valid",    32'(evt_valid), 32'd0);
        check("reset_pending",  32'(pending),   32'd0);
        check("reset_overflow", 32'(overflow),  32'd0);

        // Single rising edge on channel 0: latency 3, one event
        first = -1;
        base  = log_id.size();
        for (int j = 0; j < 8; j++) begin
            step(0, 4'b0001, 1, 4'b0000);
            if (evt_valid && first < 0) first = j;
        end
        check("latency", 32'(first), 32'd3);
        check("t1_count", 32'(log_id.size() - base), 32'd1);
        if (log_id.size() > base) check("t1_id", 32'(log_id[base]), 32'd0);
        check("t1_pending", 32'(pending), 32'd0);

        // All four rise together after reset: 0,1,2,3 two cycles apart
        step(1, 4'b0000, 0, 4'b0000);
        for (int j = 0; j < 4; j++) step(0, 4'b0000, 1, 4'b0000);
        base = log_id.size();
        for (int j = 0; j < 14; j++) step(0, 4'b1111, 1, 4'b0000);
        check("t2_count", 32'(log_id.size() - base), 32'd4);
        if (log_id.size() >= base + 4) begin
            for (int j = 0; j < 4; j++) check("t2_order", 32'(log_id[base+j]), 32'(j));
            for (int j = 1; j < 4; j++) check("t2_spacing", 32'(log_cyc[base+j] - log_cyc[base+j-1]), 32'd2);
        end

        // Held-off consumer: offer stays on channel 3 until ready
        for (int j = 0; j < 4; j++) step(0, 4'b0000, 1, 4'b0000);
        for (int j = 0; j < 14; j++) step(0, 4'b1000, 0, 4'b0000);
        check("t3_hold_id", 32'(evt_id), 32'd3);
        base = log_id.size();
        step(0, 4'b1000, 1, 4'b0000);
        check("t3_accept", 32'(log_id.size() - base), 32'd1);

        // Channel 2 edges while pending: overflow, then clear
        for (int j = 0; j < 4; j++) step(0, 4'b0000, 1, 4'b0000);
        base = log_id.size();
        for (int j = 0; j < 3; j++) step(0, 4'b0100, 0, 4'b0000);
        for (int j = 0; j < 3; j++) step(0, 4'b0000, 0, 4'b0000);
        for (int j = 0; j < 3; j++) step(0, 4'b0100, 0, 4'b0000);
        check("t4_overflow", 32'(overflow[2]), 32'd1);
        for (int j = 0; j < 6; j++) step(0, 4'b0100, 1, 4'b0000);
        check("t4_one_event", 32'(log_id.size() - base), 32'd1);
        step(0, 4'b0100, 1, 4'b0100);
        check("t4_cleared", 32'(overflow[2]), 32'd0);

        // New edge on channel 1 in the accept cycle
        for (int j = 0; j < 4; j++) step(0, 4'b0000, 1, 4'b0000);
        base = log_id.size();
        for (int j = 0; j < 5; j++) step(0, 4'b0010, 0, 4'b0000);
        for (int j = 0; j < 3; j++) step(0, 4'b0000, 0, 4'b0000);
        for (int j = 0; j < 2; j++) step(0, 4'b0010, 0, 4'b0000);
        step(0, 4'b0010, 1, 4'b0000);
        check("t5_pending1", 32'(pending[1]), 32'd1);
        check("t5_overflow1", 32'(overflow[1]), 32'd0);
        for (int j = 0; j < 6; j++) step(0, 4'b0010, 1, 4'b0000);
        n1 = 0;
        for (int j = base; j < log_id.size(); j++) if (log_id[j] == 1) n1++;
        check("t5_two_events", 32'(n1), 32'd2);

        // Reset during OFFER with three channels pending
        for (int j = 0; j < 4; j++) step(0, 4'b0000, 1, 4'b0000);
        for (int j = 0; j < 5; j++) step(0, 4'b0111, 0, 4'b0000);
        check("t6_offering", 32'(evt_valid), 32'd1);
        step(1, 4'b0111, 0, 4'b0000);
        check("t6_valid", 32'(evt_valid), 32'd0);
        check("t6_pending", 32'(pending), 32'd0);

        // Randomized traffic
        d = 4'b0111;
        for (int j = 0; j < 3000; j++) begin
            logic [3:0] clr;
            for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) d[b] = ~d[b];
            for (int b = 0; b < N; b++) clr[b] = ($urandom_range(15) == 0);
            step(($urandom_range(199) == 0), d, 1'($urandom_range(1)), clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
